bcd_to_bin: RTL
===============

Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter; the inverse of the counter-to-BCD digit path that feeds the seven-segment display.
- Takes a packed multi-digit BCD value, e.g. four digits entered on switches or read back from the display digit registers, and returns its binary value.
- Uses a start/busy/done handshake, processing one digit per clock, most significant digit first.
- Sits between the digit-entry logic and any binary consumer (counter preload, comparator).

Parameters:
- DIGITS, 4, number of BCD digits in the input.
- BIN_W, 14, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; bits [4*DIGITS-1 -: 4] hold the most significant digit.
- bin_out  output  BIN_W  registered result; holds its value until the next completion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  invalid-digit flag (see Optional Feature); held until the next start.

Behaviour:
- Reset (reset=0, asynchronous) sets: state=IDLE, bin_out=0, busy=0, done=0, err=0, acc=0, digit counter=0, shift register=0.
- States are IDLE, CONV.
- IDLE:
  - done=0 except in the single cycle after completion.
  - On an edge with start=1: capture bcd_in into the digit shift register, acc<=0, count<=0, err<=0, busy<=1, go to CONV.
  - start=0 leaves the state unchanged.
- CONV, one digit per edge:
  - acc <= acc*10 + top digit, where acc*10 is computed as (acc<<3)+(acc<<1) in BIN_W+4 bits and truncated to BIN_W.
  - Shift register moves left by 4; count increments.
  - On the edge where count reaches DIGITS-1: bin_out <= final acc value, done<=1, busy<=0, return to IDLE.
- Latency: start sampled at edge 0; the result and done appear after edge DIGITS (4 edges with the default). done lasts exactly one cycle.
- While busy=1, start is ignored and bcd_in is not resampled, so changing bcd_in mid-conversion has no effect.
- A start asserted during the done cycle is accepted, giving back-to-back conversions with no idle gap.
- start held high continuously repeats conversions every DIGITS+1 cycles.
- Reset asserted mid-conversion aborts immediately to the reset values. No done pulse is produced and bin_out returns to 0.
- bin_out changes only on a completion edge or on reset.

Optional Feature:
- Macro: BCD_ERR_CHECK_EN.
- Defined:
  - At the start edge, any captured digit greater than 9 sets err=1.
  - The conversion still runs for full latency, then bin_out is forced to 0 with done pulsing normally.
  - err clears at the next accepted start or on reset.
- Undefined:
  - err is tied to 0.
  - Digits A–F are used arithmetically with their raw value and weight 10 (e.g. digit A counts as ten).

Test Plan:
- Reset value check: hold reset=0, toggle start and bcd_in -> bin_out=0, busy=0, done=0, err=0 throughout.
- Basic conversion: bcd_in=16'h1234, start 1 cycle -> busy=1 for 4 cycles, then done=1 for one cycle with bin_out=14'd1234 (0x04D2). Also bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F).
- Zero and back-to-back: bcd_in=16'h0000 -> bin_out=0. A second start with 16'h0042 in the done cycle -> next done 5 cycles later with bin_out=42.
- Start and input ignored while busy: start pulse at cycle 2 of a 16'h0507 conversion, with bcd_in changed to 16'h1111 -> single done with bin_out=507 and no extra conversion.
- Reset mid-operation: reset=0 during cycle 2 of CONV -> immediate bin_out=0, busy=0, no done. After release, 16'h0010 converts to 10.
- Invalid digit:
  - Macro defined: bcd_in=16'h12A4 -> err=1 after the start edge, done after 4 cycles, bin_out=0.
  - Macro undefined: same stimulus -> err=0, bin_out=1304.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first, start/busy/done handshake.
// Optional invalid-digit detection (err flag, result forced to 0) enabled by defining BCD_ERR_CHECK_EN.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned IN_W  = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MUL_W = BIN_W + 4;

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    sreg_q, sreg_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [3:0]         digit_c;
  logic [MUL_W-1:0]   acc_x10_c;
  logic [BIN_W-1:0]   acc_step_c;
  logic               bad_c;

  // Next-state and datapath: acc*10 built from two shifts, widened then truncated.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    digit_c    = sreg_q[IN_W-1 -: 4];
    acc_x10_c  = (MUL_W'(acc_q) << 3) + (MUL_W'(acc_q) << 1);
    acc_step_c = BIN_W'(acc_x10_c + MUL_W'(digit_c));
    bad_c      = 1'b0;
`ifdef BCD_ERR_CHECK_EN
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_c = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          err_d   = bad_c;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d  = acc_step_c;
        sreg_d = sreg_q << 4;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          bin_d   = err_q ? '0 : acc_step_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef BCD_ERR_CHECK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule
